conv_pe_seq_ctrl: RTL and testbench

- Parametrised successor to the PE sequencing controller in the convolution datapath.
- Sequences IF/filter load, read-address generation, psum clearing and accumulation for three operating modes: single-window, multi-row filter, and psum merge.
- Adds a configurable filter-row count and multi-pass channel accumulation, both latched at start.
- Sits between the top-level start/config registers and the PE datapath (read generators, filter buffer, psum scratchpad).

---
 rtl/conv_pe_seq_ctrl.sv | 215 +++++++++++++++++++++
 tb/tb_conv_pe_seq_ctrl.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/conv_pe_seq_ctrl.sv
// PE sequencing controller: IF/filter load, read-gen arming, row stepping, multi-pass accumulation, psum merge.
// Optional build macro CONV_CTRL_PERF_EN adds a busy-cycle counter output cycle_cnt.
module conv_pe_seq_ctrl #(
   parameter int ROW_W  = 3,
   parameter int PASS_W = 6,
   parameter int MODE_W = 2
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start,
   input  logic [MODE_W-1:0] cfg_mode,
   input  logic [ROW_W-1:0]  cfg_rows,
   input  logic [PASS_W-1:0] cfg_passes,
   input  logic              full_done,
   input  logic              row_done,
   input  logic              psum_done,
   input  logic              stride_flag,
   input  logic              psum_empty,
   input  logic              psum_buf_empty,
   output logic              busy,
   output logic              done,
   output logic              err,
   output logic              reset_all,
   output logic              if_read_start,
   output logic              filt_read_start,
   output logic              start_rd_gen,
   output logic              clear_regs,
   output logic              reset_filter,
   output logic              go_next_row,
   output logic              accumulate,
   output logic              psum_ren,
   output logic              psum_same_addr,
   output logic [ROW_W-1:0]  row_idx,
   output logic [PASS_W-1:0] pass_idx
`ifdef CONV_CTRL_PERF_EN
   ,
   output logic [31:0]       cycle_cnt
`endif
);

   typedef enum logic [2:0] {
      S_IDLE, S_LOAD, S_ARM, S_RUN_S, S_RUN_R, S_MERGE, S_NEXT_PASS, S_DONE
   } state_t;

   state_t              state_q, state_d;
   logic [MODE_W-1:0]   mode_q, mode_d;
   logic [ROW_W-1:0]    rows_q, rows_d;
   logic [PASS_W-1:0]   passes_q, passes_d;
   logic [ROW_W-1:0]    row_idx_q, row_idx_d;
   logic [PASS_W-1:0]   pass_idx_q, pass_idx_d;
   logic [ROW_W-1:0]    last_row_s;
   logic [PASS_W-1:0]   last_pass_s;

   // A zero count in the latched config means a single row / single pass.
   assign last_row_s  = (rows_q == {ROW_W{1'b0}}) ? {ROW_W{1'b0}} : rows_q - ROW_W'(1);
   assign last_pass_s = (passes_q == {PASS_W{1'b0}}) ? {PASS_W{1'b0}} : passes_q - PASS_W'(1);

   assign row_idx  = row_idx_q;
   assign pass_idx = pass_idx_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         mode_q     <= {MODE_W{1'b0}};
         rows_q     <= {ROW_W{1'b0}};
         passes_q   <= {PASS_W{1'b0}};
         row_idx_q  <= {ROW_W{1'b0}};
         pass_idx_q <= {PASS_W{1'b0}};
      end else begin
         state_q    <= state_d;
         mode_q     <= mode_d;
         rows_q     <= rows_d;
         passes_q   <= passes_d;
         row_idx_q  <= row_idx_d;
         pass_idx_q <= pass_idx_d;
      end
   end

   always_comb begin
      state_d         = state_q;
      mode_d          = mode_q;
      rows_d          = rows_q;
      passes_d        = passes_q;
      row_idx_d       = row_idx_q;
      pass_idx_d      = pass_idx_q;
      busy            = 1'b0;
      done            = 1'b0;
      err             = 1'b0;
      reset_all       = 1'b0;
      if_read_start   = 1'b0;
      filt_read_start = 1'b0;
      start_rd_gen    = 1'b0;
      clear_regs      = 1'b0;
      reset_filter    = 1'b0;
      go_next_row     = 1'b0;
      accumulate      = 1'b0;
      psum_ren        = 1'b0;
      psum_same_addr  = 1'b1;

      case (state_q)
         S_IDLE: begin
            reset_all = 1'b1;
         end
         S_LOAD: begin
            busy            = 1'b1;
            if_read_start   = 1'b1;
            filt_read_start = 1'b1;
            state_d         = S_ARM;
         end
         S_ARM: begin
            busy         = 1'b1;
            start_rd_gen = 1'b1;
            case (mode_q)
               2'd0:    state_d = S_RUN_S;
               2'd1:    state_d = S_RUN_R;
               2'd2:    state_d = S_MERGE;
               default: state_d = S_DONE;
            endcase
         end
         S_RUN_S: begin
            busy       = 1'b1;
            clear_regs = psum_done | stride_flag;
            psum_ren   = (pass_idx_q != {PASS_W{1'b0}});
            if (full_done) begin
               state_d = S_NEXT_PASS;
            end else begin
               state_d = S_RUN_S;
            end
         end
         S_RUN_R: begin
            busy       = 1'b1;
            clear_regs = psum_done | stride_flag;
            if (row_done) begin
               go_next_row  = 1'b1;
               reset_filter = 1'b1;
               if (row_idx_q == last_row_s) begin
                  row_idx_d = {ROW_W{1'b0}};
                  state_d   = S_NEXT_PASS;
               end else begin
                  row_idx_d = row_idx_q + ROW_W'(1);
               end
            end else begin
               row_idx_d = row_idx_q;
            end
         end
         S_MERGE: begin
            busy           = 1'b1;
            psum_ren       = 1'b1;
            psum_same_addr = 1'b0;
            if (psum_empty) begin
               accumulate = 1'b0;
               state_d    = S_DONE;
            end else begin
               accumulate = ~psum_buf_empty;
            end
         end
         S_NEXT_PASS: begin
            busy = 1'b1;
            if (pass_idx_q == last_pass_s) begin
               state_d = S_DONE;
            end else begin
               pass_idx_d = pass_idx_q + PASS_W'(1);
               state_d    = S_ARM;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            err     = (mode_q == 2'd3);
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // A restart overrides any completion, including the done/err pulse.
      if (start) begin
         state_d    = S_LOAD;
         mode_d     = cfg_mode;
         rows_d     = cfg_rows;
         passes_d   = cfg_passes;
         row_idx_d  = {ROW_W{1'b0}};
         pass_idx_d = {PASS_W{1'b0}};
         done       = 1'b0;
         err        = 1'b0;
      end else begin
         mode_d = mode_q;
      end
   end

`ifdef CONV_CTRL_PERF_EN
   logic [31:0] cnt_q, cnt_d;

   assign cycle_cnt = cnt_q;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt_q <= 32'd0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   always_comb begin
      if (start) begin
         cnt_d = 32'd0;
      end else if (busy && (cnt_q != 32'hFFFF_FFFF)) begin
         cnt_d = cnt_q + 32'd1;
      end else begin
         cnt_d = cnt_q;
      end
   end
`endif

endmodule

// File: tb/tb_conv_pe_seq_ctrl.sv
// Scenario bench for conv_pe_seq_ctrl: per-cycle expected output vectors are queued and compared.
module tb_conv_pe_seq_ctrl;

   localparam int E_IDLE = 0, E_LOAD = 1, E_ARM = 2, E_RUNS = 3;
   localparam int E_RUNR = 4, E_MERGE = 5, E_NEXT = 6, E_DONE = 7;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic start = 1'b0;
   logic [1:0] cfg_mode = 2'd0;
   logic [2:0] cfg_rows = 3'd0;
   logic [5:0] cfg_passes = 6'd0;
   logic full_done = 1'b0, row_done = 1'b0, psum_done = 1'b0, stride_flag = 1'b0;
   logic psum_empty = 1'b0, psum_buf_empty = 1'b0;
   logic busy, done, err, reset_all, if_read_start, filt_read_start, start_rd_gen;
   logic clear_regs, reset_filter, go_next_row, accumulate, psum_ren, psum_same_addr;
   logic [2:0] row_idx;
   logic [5:0] pass_idx;
`ifdef CONV_CTRL_PERF_EN
   logic [31:0] cycle_cnt;
`endif

   typedef struct {
      int         st;
      logic [2:0] row;
      logic [5:0] pass;
      logic [6:0] in;   // {start, psum_done, stride_flag, row_done, full_done, psum_empty, psum_buf_empty}
   } stim_t;

   logic [21:0] sb[$];
   logic [21:0] obs, exp_v;
   logic exp_m3 = 1'b0;
   int checks = 0;
   int passed = 0;

   always #5 clk = ~clk;

   conv_pe_seq_ctrl dut (
      .clk(clk), .rst(rst), .start(start), .cfg_mode(cfg_mode), .cfg_rows(cfg_rows),
      .cfg_passes(cfg_passes), .full_done(full_done), .row_done(row_done),
      .psum_done(psum_done), .stride_flag(stride_flag), .psum_empty(psum_empty),
      .psum_buf_empty(psum_buf_empty), .busy(busy), .done(done), .err(err),
      .reset_all(reset_all), .if_read_start(if_read_start), .filt_read_start(filt_read_start),
      .start_rd_gen(start_rd_gen), .clear_regs(clear_regs), .reset_filter(reset_filter),
      .go_next_row(go_next_row), .accumulate(accumulate), .psum_ren(psum_ren),
      .psum_same_addr(psum_same_addr), .row_idx(row_idx), .pass_idx(pass_idx)
`ifdef CONV_CTRL_PERF_EN
      , .cycle_cnt(cycle_cnt)
`endif
   );

   assign obs = {busy, done, err, reset_all, if_read_start, filt_read_start, start_rd_gen,
                 clear_regs, reset_filter, go_next_row, accumulate, psum_ren, psum_same_addr,
                 row_idx, pass_idx};

   // Expected outputs for a given state, derived from the output table and current inputs.
   function automatic logic [21:0] expv(int st, logic [2:0] row, logic [5:0] pass);
      logic b, dn, er, ra, ifr, fr, srg, cr, rf, gn, ac, pr, sa;
      {b, dn, er, ra, ifr, fr, srg, cr, rf, gn, ac, pr} = 12'd0;
      sa = 1'b1;
      case (st)
         E_IDLE:  ra = 1'b1;
         E_LOAD:  begin b = 1'b1; ifr = 1'b1; fr = 1'b1; end
         E_ARM:   begin b = 1'b1; srg = 1'b1; end
         E_RUNS:  begin b = 1'b1; cr = psum_done | stride_flag; pr = (pass != 6'd0); end
         E_RUNR:  begin b = 1'b1; cr = psum_done | stride_flag; rf = row_done; gn = row_done; end
         E_MERGE: begin b = 1'b1; pr = 1'b1; sa = 1'b0; ac = ~psum_empty & ~psum_buf_empty; end
         E_NEXT:  b = 1'b1;
         E_DONE:  begin dn = ~start; er = exp_m3 & ~start; end
         default: ra = 1'b1;
      endcase
      return {b, dn, er, ra, ifr, fr, srg, cr, rf, gn, ac, pr, sa, row, pass};
   endfunction

   task automatic drive(stim_t s);
      {start, psum_done, stride_flag, row_done, full_done, psum_empty, psum_buf_empty} = s.in;
      sb.push_back(expv(s.st, s.row, s.pass));
   endtask

   task automatic test_reset();
      stim_t s;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      s = '{E_IDLE, 3'd0, 6'd0, 7'b0000000};
      drive(s);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL reset_state got=%h want=%h", obs, exp_v);
      else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_single();
      stim_t seq[$];
      cfg_mode = 2'd0; cfg_rows = 3'd0; cfg_passes = 6'd1; exp_m3 = 1'b0;
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b1000000});
      seq.push_back('{E_LOAD, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_ARM,  3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_RUNS, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_RUNS, 3'd0, 6'd0, 7'b0100000});
      seq.push_back('{E_RUNS, 3'd0, 6'd0, 7'b0010000});
      seq.push_back('{E_RUNS, 3'd0, 6'd0, 7'b0110000});
      seq.push_back('{E_RUNS, 3'd0, 6'd0, 7'b0001000});
      seq.push_back('{E_RUNS, 3'd0, 6'd0, 7'b0000100});
      seq.push_back('{E_NEXT, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_DONE, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b0000000});
      foreach (seq[i]) begin
         drive(seq[i]);
         #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) $display("FAIL single step%0d got=%h want=%h", i, obs, exp_v);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_multi_row();
      stim_t seq[$];
      cfg_mode = 2'd1; cfg_rows = 3'd3; cfg_passes = 6'd1; exp_m3 = 1'b0;
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b1000000});
      seq.push_back('{E_LOAD, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_ARM,  3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_RUNR, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_RUNR, 3'd0, 6'd0, 7'b0001100});
      seq.push_back('{E_RUNR, 3'd1, 6'd0, 7'b0000100});
      seq.push_back('{E_RUNR, 3'd1, 6'd0, 7'b0101000});
      seq.push_back('{E_RUNR, 3'd2, 6'd0, 7'b0010000});
      seq.push_back('{E_RUNR, 3'd2, 6'd0, 7'b0001000});
      seq.push_back('{E_NEXT, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_DONE, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b0000000});
      foreach (seq[i]) begin
         drive(seq[i]);
         #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) $display("FAIL multi_row step%0d got=%h want=%h", i, obs, exp_v);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_passes();
      stim_t seq[$];
      cfg_mode = 2'd0; cfg_rows = 3'd0; cfg_passes = 6'd4; exp_m3 = 1'b0;
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b1000000});
      seq.push_back('{E_LOAD, 3'd0, 6'd0, 7'b0000000});
      for (int p = 0; p < 4; p++) begin
         seq.push_back('{E_ARM,  3'd0, 6'(p), 7'b0000000});
         seq.push_back('{E_RUNS, 3'd0, 6'(p), 7'b0100000});
         seq.push_back('{E_RUNS, 3'd0, 6'(p), 7'b0000100});
         seq.push_back('{E_NEXT, 3'd0, 6'(p), 7'b0000000});
      end
      seq.push_back('{E_DONE, 3'd0, 6'd3, 7'b0000000});
      seq.push_back('{E_IDLE, 3'd0, 6'd3, 7'b0000000});
      foreach (seq[i]) begin
         drive(seq[i]);
         #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) $display("FAIL passes step%0d got=%h want=%h", i, obs, exp_v);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_merge();
      stim_t seq[$];
      cfg_mode = 2'd2; cfg_rows = 3'd0; cfg_passes = 6'd1; exp_m3 = 1'b0;
      seq.push_back('{E_IDLE,  3'd0, 6'd3, 7'b1000000});
      seq.push_back('{E_LOAD,  3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_ARM,   3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_MERGE, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_MERGE, 3'd0, 6'd0, 7'b0000001});
      seq.push_back('{E_MERGE, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_MERGE, 3'd0, 6'd0, 7'b0000001});
      seq.push_back('{E_MERGE, 3'd0, 6'd0, 7'b0000010});
      seq.push_back('{E_DONE,  3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_IDLE,  3'd0, 6'd0, 7'b0000000});
      foreach (seq[i]) begin
         drive(seq[i]);
         #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) $display("FAIL merge step%0d got=%h want=%h", i, obs, exp_v);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

   task automatic test_err_restart();
      stim_t seq[$];
      stim_t s;
      cfg_mode = 2'd3; cfg_rows = 3'd0; cfg_passes = 6'd1; exp_m3 = 1'b1;
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b1000000});
      seq.push_back('{E_LOAD, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_ARM,  3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_DONE, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b0000000});
      foreach (seq[i]) begin
         drive(seq[i]);
         #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) $display("FAIL err_mode step%0d got=%h want=%h", i, obs, exp_v);
         else passed++;
         @(posedge clk); #1;
      end
      seq.delete();
      cfg_mode = 2'd1; cfg_rows = 3'd2; exp_m3 = 1'b0;
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b1000000});
      seq.push_back('{E_LOAD, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_ARM,  3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_RUNR, 3'd0, 6'd0, 7'b0001000});
      seq.push_back('{E_RUNR, 3'd1, 6'd0, 7'b1000000});
      seq.push_back('{E_LOAD, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_ARM,  3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_RUNR, 3'd0, 6'd0, 7'b0001000});
      seq.push_back('{E_RUNR, 3'd1, 6'd0, 7'b0000000});
      foreach (seq[i]) begin
         drive(seq[i]);
         #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) $display("FAIL restart step%0d got=%h want=%h", i, obs, exp_v);
         else passed++;
         @(posedge clk); #1;
      end
      // Asynchronous reset while in RUN_R with row_idx=1.
      rst = 1'b1;
      s = '{E_IDLE, 3'd0, 6'd0, 7'b0000000};
      drive(s);
      #1;
      exp_v = sb.pop_front();
      checks++;
      if (obs !== exp_v) $display("FAIL midjob_reset got=%h want=%h", obs, exp_v);
      else passed++;
      @(posedge clk); #1;
      rst = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic test_back_to_back();
      stim_t seq[$];
      cfg_mode = 2'd0; cfg_rows = 3'd0; cfg_passes = 6'd0; exp_m3 = 1'b0;
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b1000000});
      seq.push_back('{E_LOAD, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_ARM,  3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_RUNS, 3'd0, 6'd0, 7'b0000100});
      seq.push_back('{E_NEXT, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_DONE, 3'd0, 6'd0, 7'b1000000});
      seq.push_back('{E_LOAD, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_ARM,  3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_RUNS, 3'd0, 6'd0, 7'b0000100});
      seq.push_back('{E_NEXT, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_DONE, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b0000000});
      foreach (seq[i]) begin
         drive(seq[i]);
         #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) $display("FAIL back_to_back step%0d got=%h want=%h", i, obs, exp_v);
         else passed++;
         @(posedge clk); #1;
      end
      seq.delete();
      cfg_mode = 2'd1; cfg_rows = 3'd0;
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b1000000});
      seq.push_back('{E_LOAD, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_ARM,  3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_RUNR, 3'd0, 6'd0, 7'b0001100});
      seq.push_back('{E_NEXT, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_DONE, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b0000000});
      foreach (seq[i]) begin
         drive(seq[i]);
         #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) $display("FAIL zero_rows step%0d got=%h want=%h", i, obs, exp_v);
         else passed++;
         @(posedge clk); #1;
      end
   endtask

`ifdef CONV_CTRL_PERF_EN
   task automatic test_perf();
      stim_t seq[$];
      cfg_mode = 2'd0; cfg_rows = 3'd0; cfg_passes = 6'd1; exp_m3 = 1'b0;
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b1000000});
      seq.push_back('{E_LOAD, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_ARM,  3'd0, 6'd0, 7'b0000000});
      for (int k = 0; k < 5; k++) seq.push_back('{E_RUNS, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_RUNS, 3'd0, 6'd0, 7'b0000100});
      seq.push_back('{E_NEXT, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_DONE, 3'd0, 6'd0, 7'b0000000});
      seq.push_back('{E_IDLE, 3'd0, 6'd0, 7'b0000000});
      foreach (seq[i]) begin
         drive(seq[i]);
         #1;
         exp_v = sb.pop_front();
         checks++;
         if (obs !== exp_v) $display("FAIL perf_job step%0d got=%h want=%h", i, obs, exp_v);
         else passed++;
         @(posedge clk); #1;
      end
      checks++;
      if (cycle_cnt !== 32'd9) $display("FAIL cycle_cnt got=%0d want=9", cycle_cnt);
      else passed++;
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (cycle_cnt !== 32'd9) $display("FAIL cycle_cnt_hold got=%0d want=9", cycle_cnt);
      else passed++;
   endtask
`endif

   initial begin
      test_reset();
      test_single();
      test_multi_row();
      test_passes();
      test_merge();
      test_err_restart();
      test_back_to_back();
`ifdef CONV_CTRL_PERF_EN
      test_perf();
`endif
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
